// File: rtl/a_secuenciador_mem.sv
// Request sequencer in front of a 32x32 level-sensitive memory.
// Single/burst reads and fill-writes; each write strobe follows a setup cycle,
// and each read word is parked in a registered response channel.
module a_secuenciador_mem #(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_wr,
  input  logic [AW-1:0] req_addr,
  input  logic [AW-1:0] req_len,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_last,
  output logic          done,
  output logic [AW-1:0] mem_index,
  output logic          mem_R_B,
  output logic          mem_w_B,
  output logic [DW-1:0] mem_DATA,
  input  logic [DW-1:0] mem_DATA_OUT
);

  typedef enum logic [2:0] {IDLE, W_SETUP, W_STROBE, R_STROBE, RESP} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] len_q, len_d;
  logic [AW-1:0] cnt_q, cnt_d;
  // mem_index_q doubles as the running burst address
  logic [AW-1:0] mem_index_q, mem_index_d;
  logic [DW-1:0] mem_data_q, mem_data_d;
  logic          mem_r_b_q, mem_r_b_d;
  logic          mem_w_b_q, mem_w_b_d;
  logic          req_ready_q, req_ready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_data_q, rsp_data_d;
  logic          rsp_last_q, rsp_last_d;
  logic          done_q, done_d;

  // Next state and next registered outputs
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    mem_index_d = mem_index_q;
    mem_data_d  = mem_data_q;
    mem_r_b_d   = 1'b0;
    mem_w_b_d   = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_last_d  = rsp_last_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        // accept only when ready is actually visible (not on the first cycle out of reset)
        if (req_valid && req_ready_q) begin
          len_d       = req_len;
          cnt_d       = '0;
          mem_index_d = req_addr;
          if (req_wr) begin
            mem_data_d = req_wdata;
            state_d    = W_SETUP;
          end else begin
            mem_data_d = '0;
            mem_r_b_d  = 1'b1;
            state_d    = R_STROBE;
          end
        end
      end
      W_SETUP: begin
        mem_w_b_d = 1'b1;
        state_d   = W_STROBE;
      end
      W_STROBE: begin
        // new index is launched on the same edge the strobe drops
        if (cnt_q == len_q) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          mem_index_d = mem_index_q + AW'(1);
          cnt_d       = cnt_q + AW'(1);
          state_d     = W_SETUP;
        end
      end
      R_STROBE: begin
        rsp_data_d  = mem_DATA_OUT;
        rsp_last_d  = (cnt_q == len_q);
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (rsp_last_q) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            mem_index_d = mem_index_q + AW'(1);
            cnt_d       = cnt_q + AW'(1);
            mem_r_b_d   = 1'b1;
            state_d     = R_STROBE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    req_ready_d = (state_d == IDLE);
  end

  // State and output registers, synchronous active-low clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      mem_index_q <= '0;
      mem_data_q  <= '0;
      mem_r_b_q   <= 1'b0;
      mem_w_b_q   <= 1'b0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      mem_index_q <= mem_index_d;
      mem_data_q  <= mem_data_d;
      mem_r_b_q   <= mem_r_b_d;
      mem_w_b_q   <= mem_w_b_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_last_q  <= rsp_last_d;
      done_q      <= done_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_last  = rsp_last_q;
  assign done      = done_q;
  assign mem_index = mem_index_q;
  assign mem_R_B   = mem_r_b_q;
  assign mem_w_B   = mem_w_b_q;
  assign mem_DATA  = mem_data_q;

endmodule
